// File: rtl/half_adder.sv
// half_adder: pipelined per-lane half adder with valid flag and saturating carry-event counter
module half_adder #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_count
);
  if (WIDTH < 1 || WIDTH > 64 || LATENCY < 1 || LATENCY > 4 || CNT_W < 2 || CNT_W > 32) begin : g_bad_param
    $error("half_adder: illegal parameters WIDTH=%0d LATENCY=%0d CNT_W=%0d", WIDTH, LATENCY, CNT_W);
  end
  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   sum_q   [LATENCY];
  logic [WIDTH-1:0]   carry_q [LATENCY];
  logic [CNT_W-1:0]   count_q, count_d;
  // Pipeline: valid shifts every cycle, data registers only load behind a valid entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        sum_q[i]   <= '0;
        carry_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        sum_q[0]   <= a ^ b;
        carry_q[0] <= a & b;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          sum_q[i]   <= sum_q[i-1];
          carry_q[i] <= carry_q[i-1];
        end
      end
    end
  end
  // Output gating hides held data when the last stage is empty; counter saturates at all-ones
  always_comb begin
    out_valid   = valid_q[LATENCY-1];
    sum         = out_valid ? sum_q[LATENCY-1] : '0;
    carry       = out_valid ? carry_q[LATENCY-1] : '0;
    carry_any   = |carry;
    count_d     = (out_valid && carry_any && !(&count_q)) ? count_q + CNT_W'(1) : count_q;
    carry_count = count_q;
  end
  // Carry event counter, cleared only by reset
  always_ff @(posedge clk) begin
    count_q <= rst ? '0 : count_d;
  end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: random and directed stimulus against a queue-based reference model
module tb_half_adder;
  localparam int W = 8;
  localparam int L = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0;
  logic rst, in_valid;
  logic [W-1:0] a, b, sum, carry;
  logic out_valid, carry_any;
  logic [CW-1:0] carry_count;
  typedef struct {int n; logic [W-1:0] a; logic [W-1:0] b;} ent_t;
  ent_t q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, exp_cnt = 0;
  bit exp_v = 0;
  logic [W-1:0] exp_a = '0, exp_b = '0;
  half_adder #(.WIDTH(W), .LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .sum(sum), .carry(carry),
    .carry_any(carry_any), .carry_count(carry_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [W-1:0] es, ec;
    rst = r; in_valid = v; a = ia; b = ib;
    @(posedge clk);
    cyc++;
    if (r) exp_cnt = 0;
    else if (exp_v && (exp_a & exp_b) != 0 && exp_cnt < CMAX) exp_cnt++;
    if (r) q.delete();
    else if (v) q.push_back('{cyc, ia, ib});
    exp_v = 0;
    if (q.size() > 0 && q[0].n == cyc - L + 1) begin
      exp_v = 1; exp_a = q[0].a; exp_b = q[0].b;
      void'(q.pop_front());
    end
    es = exp_v ? ((exp_a + exp_b) & {W{1'b0}}) | (exp_a ^ exp_b) : '0;
    ec = exp_v ? (exp_a & exp_b) : '0;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("sum", 64'(sum), 64'(es));
    chk("carry", 64'(carry), 64'(ec));
    chk("carry_any", 64'(carry_any), 64'(ec != 0));
    chk("carry_count", 64'(carry_count), 64'(exp_cnt));
  endtask
  initial begin
    rst = 1; in_valid = 0; a = '0; b = '0;
    @(negedge clk);
    step(1, 0, '0, '0);
    step(1, 1, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0);
    step(0, 1, 8'hF0, 8'h3C);
    step(0, 1, 8'h0F, 8'hF0);
    step(0, 0, '0, '0);
    chk("dir_sum_cc", 64'(sum), 64'hCC);
    chk("dir_carry_30", 64'(carry), 64'h30);
    step(0, 0, '0, '0);
    chk("dir_sum_ff", 64'(sum), 64'hFF);
    chk("dir_any_0", 64'(carry_any), 64'h0);
    step(0, 1, 8'h01, 8'h01);
    step(0, 1, 8'h03, 8'h01);
    step(1, 0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0);
    chk("mid_reset_cnt", 64'(carry_count), 64'h0);
    step(1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0);
    for (int i = 0; i < CMAX + 4; i++) step(0, 1, 8'h81, 8'h01);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0);
    chk("saturate", 64'(carry_count), 64'(CMAX));
    step(1, 0, '0, '0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 3, $urandom_range(2) != 0, W'($urandom), W'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
